// File: rtl/ahb_to_apb_bridge.sv
// AHB-lite slave that turns each accepted transfer into one APB4 transfer,
// holding HREADYout low while the APB cycle runs and mapping PSLVERR/timeout to ERROR.
module ahb_to_apb_bridge #(
  parameter logic [7:0] P_TIMEOUT = 8'd255
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADYin,
  output logic        HREADYout,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA,
  output logic [31:0] PADDR,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  output logic [3:0]  PSTRB,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WWAIT  = 3'd1,
    S_SETUP  = 3'd2,
    S_ACCESS = 3'd3,
    S_DONE   = 3'd4,
    S_ERR1   = 3'd5,
    S_ERR2   = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic [31:0] hrdata_q, hrdata_d;
  logic [3:0]  pstrb_q, pstrb_d;
  logic        pwrite_q, pwrite_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        ready_state;
  logic        accept;
  logic        timeout_hit;
  logic [3:0]  strb_calc;
  logic        unused_htrans0;

  assign unused_htrans0 = HTRANS[0];

  // Handshake: an address phase is taken only when HSEL & HTRANS[1] & HREADYin
  // are all high on an edge where this slave is itself ready (IDLE/DONE/ERR2).
  assign ready_state = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR2);
  assign accept      = ready_state && HSEL && HTRANS[1] && HREADYin;
  assign timeout_hit = (P_TIMEOUT != 8'd0) && (cnt_q == (P_TIMEOUT - 8'd1));

  always_comb begin
    strb_calc = 4'b1111;
    case (HSIZE)
      3'b000:  strb_calc = 4'b0001 << HADDR[1:0];
      3'b001:  strb_calc = 4'b0011 << {HADDR[1], 1'b0};
      default: strb_calc = 4'b1111;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR2: begin
        if (accept) begin
          state_d = HWRITE ? S_WWAIT : S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WWAIT: state_d = S_SETUP;
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (PREADY) begin
          state_d = PSLVERR ? S_ERR1 : S_DONE;
        end else if (timeout_hit) begin
          state_d = S_ERR1;
        end
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    HREADYout = 1'b1;
    HRESP     = 2'b00;
    case (state_q)
      S_WWAIT: HREADYout = 1'b0;
      S_SETUP: begin
        PSEL      = 1'b1;
        HREADYout = 1'b0;
      end
      S_ACCESS: begin
        PSEL      = 1'b1;
        PENABLE   = 1'b1;
        HREADYout = 1'b0;
      end
      S_ERR1: begin
        HREADYout = 1'b0;
        HRESP     = 2'b01;
      end
      S_ERR2: HRESP = 2'b01;
      default: begin
        HREADYout = 1'b1;
        HRESP     = 2'b00;
      end
    endcase
  end

  // APB-side registers hold their values between transfers.
  always_comb begin
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pstrb_d  = pstrb_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;
    cnt_d    = cnt_q;
    if (accept) begin
      paddr_d  = HADDR;
      pwrite_d = HWRITE;
      pstrb_d  = HWRITE ? strb_calc : 4'b0000;
    end
    if (state_q == S_WWAIT) begin
      pwdata_d = HWDATA;
    end
    if (state_q == S_SETUP) begin
      cnt_d = 8'd0;
    end
    if (state_q == S_ACCESS) begin
      if (PREADY) begin
        if (!PSLVERR && !pwrite_q) begin
          hrdata_d = PRDATA;
        end
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      paddr_q  <= 32'd0;
      pwrite_q <= 1'b0;
      pstrb_q  <= 4'd0;
      pwdata_q <= 32'd0;
      hrdata_q <= 32'd0;
      cnt_q    <= 8'd0;
    end else begin
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pstrb_q  <= pstrb_d;
      pwdata_q <= pwdata_d;
      hrdata_q <= hrdata_d;
      cnt_q    <= cnt_d;
    end
  end

  assign PADDR       = paddr_q;
  assign PWRITE      = pwrite_q;
  assign PSTRB       = pstrb_q;
  assign PWDATA      = pwdata_q;
  assign HRDATA      = hrdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ahb_to_apb_bridge.sv
// Bench for ahb_to_apb_bridge: AHB master driver, APB slave responder and a
// transaction-level model predicting wait states, response and data per transfer.
module tb_ahb_to_apb_bridge;

  localparam int TO = 4;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADYin;
  logic        HREADYout;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;
  logic [31:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [2:0]  dbg_state;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] last_rdata;
  logic [31:0] last_wdata;
  logic [31:0] exp_q[$];

  ahb_to_apb_bridge #(.P_TIMEOUT(8'(TO))) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADYin(HREADYin),
    .HREADYout(HREADYout), .HRESP(HRESP), .HRDATA(HRDATA), .PADDR(PADDR),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Byte lanes covered by an access: size-aligned block of 1/2/4 bytes.
  function automatic logic [3:0] model_strb(input logic wr, input logic [31:0] a,
                                            input logic [2:0] sz);
    logic [3:0] s;
    int nb;
    int base;
    s = 4'b0000;
    if (wr) begin
      nb   = (sz >= 3'd2) ? 4 : (1 << sz);
      base = (int'(a[1:0]) / nb) * nb;
      for (int i = 0; i < 4; i++) begin
        if (i >= base && i < base + nb) s[i] = 1'b1;
      end
    end
    return s;
  endfunction

  task automatic check_reset_vals(input string p);
    chk({p, "_psel"},    32'(PSEL),      32'd0);
    chk({p, "_penable"}, 32'(PENABLE),   32'd0);
    chk({p, "_pwrite"},  32'(PWRITE),    32'd0);
    chk({p, "_paddr"},   PADDR,          32'd0);
    chk({p, "_pwdata"},  PWDATA,         32'd0);
    chk({p, "_pstrb"},   32'(PSTRB),     32'd0);
    chk({p, "_hrdata"},  HRDATA,         32'd0);
    chk({p, "_hready"},  32'(HREADYout), 32'd1);
    chk({p, "_hresp"},   32'(HRESP),     32'd0);
  endtask

  // Idle bus cycles with address-phase inputs that must never be accepted.
  task automatic idle(input int n);
    repeat (n) begin
      HSEL = 1'b1; HTRANS = 2'b10; HREADYin = 1'b1;
      case ($urandom_range(0, 3))
        0: HSEL = 1'b0;
        1: HTRANS = 2'b01;
        2: HTRANS = 2'b00;
        default: HREADYin = 1'b0;
      endcase
      HADDR = $urandom;
      HWRITE = 1'($urandom_range(0, 1));
      @(posedge HCLK);
      @(negedge HCLK);
      chk("idle_no_psel", 32'(PSEL), 32'd0);
      chk("idle_ready", 32'(HREADYout), 32'd1);
    end
    HSEL = 1'b0; HTRANS = 2'b00; HREADYin = 1'b1;
  endtask

  // Driver + APB responder + model for one transfer. Called at a negedge while
  // the bridge is ready; returns at the negedge of the completing cycle.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] sz,
                      input logic [31:0] wdata, input int low, input logic slverr,
                      input logic [31:0] rdata);
    int exp_acc, exp_waits, waits, acc, setup, viol;
    logic exp_err, done;
    logic [31:0] s_paddr, s_pwdata;
    logic [3:0] s_pstrb;
    logic s_pwrite;
    logic [1:0] last_resp;

    if (low < TO) begin
      exp_acc = low + 1;
      exp_err = slverr;
    end else begin
      exp_acc = TO;
      exp_err = 1'b1;
    end
    exp_waits = (wr ? 1 : 0) + 1 + exp_acc + (exp_err ? 1 : 0);
    if (wr) last_wdata = wdata;
    if (!wr && !exp_err) last_rdata = rdata;
    exp_q.push_back(last_rdata);

    HSEL = 1'b1; HTRANS = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b11;
    HADDR = addr; HWRITE = wr; HSIZE = sz; HREADYin = 1'b1; HWDATA = $urandom;
    @(posedge HCLK);

    waits = 0; acc = 0; setup = 0; viol = 0; done = 1'b0;
    s_paddr = 'x; s_pwdata = 'x; s_pstrb = 'x; s_pwrite = 1'bx; last_resp = 2'bxx;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge HCLK);
      if (c == 0) begin
        HSEL = 1'($urandom_range(0, 1)); HTRANS = 2'b00; HWDATA = wdata;
      end else begin
        HWDATA = $urandom;
      end
      if (PENABLE && !PSEL) viol++;
      if (PSEL && !PENABLE) begin
        setup++;
        s_paddr = PADDR; s_pwdata = PWDATA; s_pstrb = PSTRB; s_pwrite = PWRITE;
      end
      if (PSEL && PENABLE) begin
        acc++;
        PREADY = (acc > low);
      end else begin
        PREADY = 1'($urandom_range(0, 1));
      end
      PSLVERR = (PSEL && PENABLE && PREADY) ? slverr : 1'($urandom_range(0, 1));
      PRDATA  = (PSEL && PENABLE && PREADY) ? rdata : $urandom;
      if (HREADYout) begin
        done = 1'b1;
      end else begin
        waits++;
        last_resp = HRESP;
      end
    end

    chk("completed",        32'(done),      32'd1);
    chk("wait_states",      32'(waits),     32'(exp_waits));
    chk("setup_cycles",     32'(setup),     32'd1);
    chk("access_cycles",    32'(acc),       32'(exp_acc));
    chk("penable_wo_psel",  32'(viol),      32'd0);
    chk("paddr",            s_paddr,        addr);
    chk("pwrite",           32'(s_pwrite),  32'(wr));
    chk("pstrb",            32'(s_pstrb),   32'(model_strb(wr, addr, sz)));
    chk("pwdata",           s_pwdata,       last_wdata);
    chk("last_wait_hresp",  32'(last_resp), exp_err ? 32'd1 : 32'd0);
    chk("final_hresp",      32'(HRESP),     exp_err ? 32'd1 : 32'd0);
    chk("hrdata",           HRDATA,         exp_q.pop_front());
    chk("paddr_hold",       PADDR,          addr);
    HSEL = 1'b0; HTRANS = 2'b00;
  endtask

  // Write stalled in ACCESS, then reset: everything back to reset values.
  task automatic reset_mid();
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0000_0040; HWRITE = 1'b1;
    HSIZE = 3'd2; HREADYin = 1'b1;
    @(posedge HCLK);
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h1234_5678; PREADY = 1'b0;
    @(negedge HCLK);
    @(negedge HCLK);
    chk("rstmid_in_access", 32'(PSEL && PENABLE), 32'd1);
    HRESET = 1'b1;
    @(negedge HCLK);
    check_reset_vals("rstmid");
    HRESET = 1'b0;
    last_rdata = 32'd0;
    last_wdata = 32'd0;
  endtask

  initial begin
    logic wr, b2b;
    HRESET = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HADDR = 32'd0; HWRITE = 1'b0;
    HSIZE = 3'd0; HWDATA = 32'd0; HREADYin = 1'b1; PRDATA = 32'd0; PREADY = 1'b0;
    PSLVERR = 1'b0; last_rdata = 32'd0; last_wdata = 32'd0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    check_reset_vals("rst");
    HRESET = 1'b0;

    xfer(1'b0, 32'h0000_0010, 3'd2, 32'd0, 0, 1'b0, 32'hDEAD_BEEF);
    idle(1);
    xfer(1'b1, 32'h0000_0103, 3'd0, 32'hAA00_0000, 0, 1'b0, $urandom);
    idle(1);
    xfer(1'b0, 32'h0000_0020, 3'd2, 32'd0, 3, 1'b0, 32'h0BAD_F00D);
    idle(1);
    xfer(1'b1, 32'h0000_0030, 3'd1, 32'h5555_6666, 1, 1'b1, $urandom);
    xfer(1'b0, 32'h0000_0034, 3'd2, 32'd0, 0, 1'b0, 32'hCAFE_0001);
    idle(1);
    xfer(1'b0, 32'h0000_0044, 3'd2, 32'd0, 10, 1'b0, 32'h7777_7777);
    idle(2);
    xfer(1'b1, 32'h0000_0052, 3'd1, 32'h1357_9BDF, 0, 1'b0, $urandom);
    xfer(1'b0, 32'h0000_0058, 3'd2, 32'd0, 0, 1'b0, 32'h2468_ACE0);
    idle(1);
    reset_mid();

    for (int t = 0; t < 60; t++) begin
      wr  = 1'($urandom_range(0, 1));
      b2b = 1'($urandom_range(0, 1));
      xfer(wr, $urandom, 3'($urandom_range(0, 7)), $urandom, $urandom_range(0, 5),
           1'($urandom_range(0, 4) == 0), $urandom);
      if (!b2b) idle($urandom_range(1, 2));
    end
    idle(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ahb_to_apb_bridge.md
# ahb_to_apb_bridge

AHB-lite slave that converts each accepted AHB-lite transfer into one APB4 transfer on a single APB master port. It sits downstream of the 3-slave AHB-lite interconnect, on one of its HSELx/HRDATAx/HRESPx/HREADYx slave ports, and fronts a cluster of low-speed APB peripherals. It inserts AHB wait states while the APB transfer runs. PSLVERR or an access timeout is returned as a two-cycle AHB ERROR response.

## Interface
- P_TIMEOUT, 8'd255: maximum ACCESS cycles waiting for PREADY; 0 disables the timeout.
- HCLK  in  1  clock; all logic on rising edge.
- HRESET  in  1  reset; synchronous and active-high.
- HSEL  in  1  slave select from the interconnect decoder.
- HADDR  in  32  AHB address.
- HTRANS  in  2  transfer type; only NONSEQ/SEQ (HTRANS[1]=1) start a transfer.
- HWRITE  in  1  1=write.
- HSIZE  in  3  byte/half/word; larger sizes are treated as word.
- HWDATA  in  32  write data, valid in the data phase.
- HREADYin  in  1  bus HREADY (HREADY from the interconnect).
- HREADYout  out  1  this slave's ready, to HREADYx.
- HRESP  out  2  2'b00 OKAY, 2'b01 ERROR.
- HRDATA  out  32  registered read data.
- PADDR  out  32  APB address, registered HADDR.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  32  registered write data.
- PSTRB  out  4  byte strobes; 4'b0000 on reads.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error, sampled with PREADY.

## Operation
- Accept condition: HSEL & HTRANS[1] & HREADYin in states IDLE, DONE or ERR2.
  - On accept, register HADDR, HWRITE and PSTRB.
  - PSTRB is derived from HSIZE and HADDR[1:0]: byte gives 4'b0001<<HADDR[1:0]; half gives 4'b0011<<{HADDR[1],1'b0}; word gives 4'b1111.
  - Next state is WWAIT for a write, SETUP for a read.
- Any other input in IDLE, DONE or ERR2 goes to IDLE.
- WWAIT:
  - Capture HWDATA into PWDATA.
  - HREADYout=0.
  - Next state SETUP.
- SETUP:
  - PSEL=1, PENABLE=0, HREADYout=0.
  - Clear the timeout counter.
  - Next state ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1, HREADYout=0.
  - PREADY=1 with PSLVERR=0: capture PRDATA into HRDATA on reads, next state DONE.
  - PREADY=1 with PSLVERR=1: next state ERR1.
  - PREADY=0: increment the counter. When the counter reaches P_TIMEOUT-1 (P_TIMEOUT≠0), next state ERR1 and drop PSEL/PENABLE.
  - Otherwise stay in ACCESS.
- DONE: HREADYout=1, HRESP=OKAY, PSEL=0.
- ERR1: HREADYout=0, HRESP=ERROR, PSEL=0.
- ERR2: HREADYout=1, HRESP=ERROR. Next state IDLE or a new accept.
- IDLE: HREADYout=1, HRESP=OKAY.
- HRDATA holds its last value until the next successful read.
- PADDR, PWRITE, PWDATA and PSTRB hold between transfers.
- Not supported: locked transfers and HPROT (not ported). BUSY is treated as IDLE.

## Timing
- Reset values (HRESET sampled high at an edge):
  - State IDLE.
  - PSEL=0, PENABLE=0, PWRITE=0.
  - PADDR=0, PWDATA=0, PSTRB=0, HRDATA=0.
  - HREADYout=1, HRESP=00, counter=0.
- Reset mid-transfer aborts the APB cycle at the next edge. No response is given for the dropped transfer.
- Read, PREADY immediate: address phase T0, SETUP T1, ACCESS T2, DONE T3. HRDATA is valid with HREADYout=1 in T3 (2 wait states).
- Write, PREADY immediate: T0 address, WWAIT T1, SETUP T2, ACCESS T3, DONE T4 (3 wait states).
- Each PREADY-low ACCESS cycle adds one wait state.
- Back-to-back transfers: an address phase sampled in DONE or ERR2 starts at the next edge with no idle cycle.
- Error response: ERR1 (HREADYout=0, HRESP=01) followed by ERR2 (HREADYout=1, HRESP=01).
- Timeout with P_TIMEOUT=N gives exactly N ACCESS cycles, then ERR1.
- PENABLE never asserts without PSEL. PSEL never drops inside ACCESS except on timeout.

## Test plan
- Reset, then word read 0x0000_0010, PRDATA=0xDEAD_BEEF, PREADY=1 -> PSEL high T1–T2, PENABLE T2 only, HRDATA=0xDEAD_BEEF with HREADYout=1 at T3.
- Byte write to 0x...03, HWDATA=0xAA00_0000 -> PSTRB=4'b1000, PWDATA=0xAA00_0000 during SETUP/ACCESS, OKAY at T4.
- Read with PREADY low 3 ACCESS cycles -> HREADYout low 5 cycles, PRDATA captured only on the PREADY cycle.
- PSLVERR=1 on a write -> HRESP=01 for two cycles, HREADYout 0 then 1. A read accepted in ERR2 completes OKAY.
- P_TIMEOUT=4, PREADY stuck low -> 4 ACCESS cycles, PSEL drops, ERROR response. Also HRESET high in ACCESS -> all outputs at reset values next cycle.
- Back-to-back write then read -> the read's SETUP follows the write's DONE by one cycle, with correct PADDR and PWRITE switching.
